// File: rtl/gmm_bus_arbiter.sv
// rtl/gmm_bus_arbiter.sv - round-robin shared-bus arbiter with bounded burst tenure
//
// Grants one of NREQ requesters the shared bus for up to BURST beats. Each
// tenure ends with one RELEASE cycle that pulses done. The round-robin search
// starts one index past the previous owner.
//
// Ports:
//   clk    - single clock, rising edge
//   rst    - asynchronous active-low reset
//   en     - arbitration enable; gates only new grants
//   req    - per-requester request, level-held
//   beat   - shared bus accepted one word for the current owner
//   grant  - registered one-hot grant, zero when no owner
//   owner  - index of the current or most recent owner
//   busy   - high while a tenure is active
//   done   - one-cycle pulse when a tenure ends
module gmm_bus_arbiter #(
    parameter int NREQ  = 4,
    parameter int BURST = 16,
    parameter int IDXW  = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [NREQ-1:0] req,
    input  logic            beat,
    output logic [NREQ-1:0] grant,
    output logic [IDXW-1:0] owner,
    output logic            busy,
    output logic            done
);

    localparam int CW = (BURST > 1) ? $clog2(BURST) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t          state, state_d;
    logic [CW-1:0]   cnt, cnt_d;
    logic [IDXW-1:0] last, last_d;
    logic [IDXW-1:0] owner_d;
    logic [NREQ-1:0] grant_d;
    logic            busy_d, done_d;
    logic [IDXW-1:0] winner;
    logic [IDXW-1:0] cand;
    logic            found;
    logic            burst_end;

    // Round-robin search: first asserted request at last+1, last+2, ... wrapping.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        cand   = '0;
        for (int i = 1; i <= NREQ; i++) begin
            cand = IDXW'((int'(last) + i) % NREQ);
            if (!found && req[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        owner_d   = owner;
        last_d    = last;
        grant_d   = '0;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        burst_end = 1'b0;
        case (state)
            IDLE: begin
                if (en && found) begin
                    state_d = GRANT;
                    owner_d = winner;
                    cnt_d   = '0;
                    grant_d = NREQ'(1) << winner;
                    busy_d  = 1'b1;
                end
            end
            GRANT: begin
                burst_end = beat && (cnt == CW'(BURST - 1));
                // Saturate at BURST-1 so the counter never wraps on the final beat.
                if (beat && !burst_end) begin
                    cnt_d = cnt + CW'(1);
                end
                if (burst_end || !req[owner]) begin
                    state_d = RELEASE;
                    done_d  = 1'b1;
                end else begin
                    grant_d = grant;
                    busy_d  = 1'b1;
                end
            end
            RELEASE: begin
                state_d = IDLE;
                last_d  = owner;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
            last  <= IDXW'(NREQ - 1);
            owner <= '0;
            grant <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            last  <= last_d;
            owner <= owner_d;
            grant <= grant_d;
            busy  <= busy_d;
            done  <= done_d;
        end
    end

endmodule

// File: tb/tb_gmm_bus_arbiter.sv
// tb/tb_gmm_bus_arbiter.sv - randomized bench for gmm_bus_arbiter with a tenure-level model
module tb_gmm_bus_arbiter;

    localparam int NREQ = 4;

    logic            clk;
    logic            rst;
    logic            en;
    logic [NREQ-1:0] req;
    logic            beat;

    logic [NREQ-1:0] grant_a, grant_b;
    logic [1:0]      owner_a, owner_b;
    logic            busy_a, busy_b, done_a, done_b;

    int n_checks;
    int n_fail;

    // Model state per DUT: 0 = BURST 16, 1 = BURST 1
    int bursts   [2];
    int m_active [2];
    int m_done   [2];
    int m_owner  [2];
    int m_last   [2];
    int m_beats  [2];

    gmm_bus_arbiter #(.NREQ(NREQ), .BURST(16), .IDXW(2)) u_dut_a (
        .clk(clk), .rst(rst), .en(en), .req(req), .beat(beat),
        .grant(grant_a), .owner(owner_a), .busy(busy_a), .done(done_a)
    );

    gmm_bus_arbiter #(.NREQ(NREQ), .BURST(1), .IDXW(2)) u_dut_b (
        .clk(clk), .rst(rst), .en(en), .req(req), .beat(beat),
        .grant(grant_b), .owner(owner_b), .busy(busy_b), .done(done_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_active[k] = 0;
            m_done[k]   = 0;
            m_owner[k]  = 0;
            m_last[k]   = NREQ - 1;
            m_beats[k]  = 0;
        end
    endtask

    // One clock edge of a tenure-level view: a tenure collects beats until it
    // has BURST of them or its requester lets go, then a done cycle follows,
    // then an idle cycle in which the next owner is chosen.
    task automatic model_step(input int k);
        int c;
        bit hit;
        if (m_done[k] != 0) begin
            m_done[k] = 0;
        end else if (m_active[k] != 0) begin
            if (beat) m_beats[k]++;
            if (m_beats[k] >= bursts[k] || !req[m_owner[k]]) begin
                m_active[k] = 0;
                m_done[k]   = 1;
                m_last[k]   = m_owner[k];
            end
        end else if (en && req != '0) begin
            hit = 0;
            for (int i = 1; i <= NREQ; i++) begin
                c = (m_last[k] + i) % NREQ;
                if (!hit && req[c]) begin
                    hit = 1;
                    m_owner[k] = c;
                end
            end
            m_active[k] = 1;
            m_beats[k]  = 0;
        end
    endtask

    function automatic logic [3:0] exp_grant(input int k);
        return (m_active[k] != 0) ? 4'(1 << m_owner[k]) : 4'b0000;
    endfunction

    task automatic check_outputs();
        check_eq("grant_b16", grant_a, exp_grant(0));
        check_eq("busy_b16",  busy_a,  m_active[0] != 0);
        check_eq("done_b16",  done_a,  m_done[0] != 0);
        check_eq("owner_b16", owner_a, m_owner[0]);
        check_eq("grant_b1",  grant_b, exp_grant(1));
        check_eq("busy_b1",   busy_b,  m_active[1] != 0);
        check_eq("done_b1",   done_b,  m_done[1] != 0);
        check_eq("owner_b1",  owner_b, m_owner[1]);
    endtask

    task automatic drive_cycle(input logic e, input logic [3:0] r, input logic b);
        @(negedge clk);
        en   = e;
        req  = r;
        beat = b;
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
        check_outputs();
    endtask

    // Reset lands right after a negedge and must clear outputs without a clock.
    task automatic apply_reset(input int cycles);
        @(negedge clk);
        rst = 1'b0;
        #1;
        model_reset();
        check_outputs();
        en  = 1'b0;
        req = '0;
        repeat (cycles) @(negedge clk);
        rst = 1'b1;
    endtask

    logic [3:0] r_rand;

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        bursts[0] = 16;
        bursts[1] = 1;
        rst  = 1'b0;
        en   = 1'b0;
        req  = '0;
        beat = 1'b0;
        model_reset();

        apply_reset(2);

        // Two pending requesters, continuous beats
        drive_cycle(1'b1, 4'b0101, 1'b1);
        check_eq("first_grant", grant_a, 32'h1);
        repeat (15) drive_cycle(1'b1, 4'b0101, 1'b1);
        drive_cycle(1'b1, 4'b0101, 1'b1);
        check_eq("burst_done", done_a, 32'h1);
        drive_cycle(1'b1, 4'b0101, 1'b1);
        check_eq("dead_cycle", grant_a, 32'h0);
        drive_cycle(1'b1, 4'b0101, 1'b0);
        check_eq("second_grant", grant_a, 32'h4);

        // Owner 2 withdraws after 5 beats; search then resumes at 3
        repeat (5) drive_cycle(1'b1, 4'b0101, 1'b1);
        drive_cycle(1'b1, 4'b0001, 1'b0);
        check_eq("withdraw_done", done_a, 32'h1);
        drive_cycle(1'b1, 4'b1001, 1'b0);
        drive_cycle(1'b1, 4'b1001, 1'b0);
        check_eq("rr_after_2", grant_a, 32'h8);
        repeat (3) drive_cycle(1'b1, 4'b0000, 1'b0);

        // Enable gating, then en dropped mid-burst
        repeat (3) drive_cycle(1'b0, 4'b0010, 1'b1);
        check_eq("en_low_grant", grant_a, 32'h0);
        drive_cycle(1'b1, 4'b0010, 1'b0);
        check_eq("en_high_grant", grant_a, 32'h2);
        repeat (15) drive_cycle(1'b0, 4'b0010, 1'b1);
        check_eq("en_low_busy", busy_a, 32'h1);
        drive_cycle(1'b0, 4'b0010, 1'b1);
        check_eq("en_low_done", done_a, 32'h1);
        repeat (2) drive_cycle(1'b0, 4'b0000, 1'b0);

        // Reset mid-tenure of owner 1
        drive_cycle(1'b1, 4'b0010, 1'b0);
        repeat (7) drive_cycle(1'b1, 4'b0010, 1'b1);
        apply_reset(2);
        drive_cycle(1'b1, 4'b0010, 1'b0);
        check_eq("post_reset_grant", grant_a, 32'h2);
        repeat (20) drive_cycle(1'b1, 4'b0000, 1'b0);

        // All requesting: order 0,1,2,3,0 on the BURST 16 instance
        apply_reset(1);
        for (int t = 0; t < 5; t++) begin
            drive_cycle(1'b1, 4'b1111, 1'b1);
            check_eq("rr_order", grant_a, 32'h1 << (t % 4));
            repeat (16) drive_cycle(1'b1, 4'b1111, 1'b1);
            check_eq("rr_done", done_a, 32'h1);
            drive_cycle(1'b1, 4'b1111, 1'b1);
        end

        // Randomized traffic with level-held requests and occasional reset
        r_rand = 4'($urandom_range(15));
        for (int n = 0; n < 4000; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                if ($urandom_range(9) == 0) r_rand[i] = ~r_rand[i];
            end
            if ($urandom_range(399) == 0) begin
                apply_reset($urandom_range(1, 3));
            end else begin
                drive_cycle($urandom_range(7) != 0, r_rand, $urandom_range(3) != 0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
